rgb_fade_sequencer: RTL and testbench
=====================================

Name: rgb_fade_sequencer

Overview:
Avalon-MM slave that steps the three duty-cycle values driving the RGB PWM channels through up to NUM_KEYS programmed colour keyframes. It ramps each channel linearly by ±1 LSB per step tick toward the active keyframe, holds, then advances. It sits in the RGB LED controller component between the HPS lightweight bridge and the existing per-channel PWM generators, whose outputs form rgb_output[2:0]. Software loads keyframes and timing, sets enable, and the sequencer runs autonomously.

Parameters:
DUTY_W, 8, duty-cycle width per channel; legal range 1..10, so three channels fit in one 32-bit key word.
NUM_KEYS, 4, number of keyframe registers; legal range 1..8.
DIV_W, 24, width of the step-tick prescaler.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  4  register word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
duty_red  out  DUTY_W  red duty to PWM generator
duty_green  out  DUTY_W  green duty to PWM generator
duty_blue  out  DUTY_W  blue duty to PWM generator
busy  out  1  high in RAMP or HOLD
seq_done  out  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on reset_n. Reset clears every register, duty output, the FSM (to IDLE), the key index and the counters. avs_readdata, busy and seq_done reset to 0.
- Register map (word addresses):
  - 0 CTRL: bit0 enable, bit1 loop.
  - 1 STEP_DIV[DIV_W-1:0]: clocks per step tick; 0 is treated as 1.
  - 2 HOLD_STEPS[15:0]: hold duration in step ticks.
  - 3 KEYS_USED[3:0]: number of active keys; 0 is treated as 1, values above NUM_KEYS saturate to NUM_KEYS.
  - 4..4+NUM_KEYS-1 KEY[i]: {red, green, blue}, each DUTY_W wide, packed from bit 0 with blue in the LSBs.
  - 15 STATUS (read-only): [1:0] state, [6:4] key index, [8] busy.
  - Unmapped reads return 0. Writes to unmapped addresses and to STATUS are ignored.
- Bus timing: readdata is valid exactly one cycle after avs_read. There is no waitrequest. Writes take effect on the next clock edge.
- Step tick: a prescaler counts 0..STEP_DIV-1 and pulses tick for one cycle at terminal count. The prescaler resets to 0 on any FSM transition into RAMP.
- FSM states: IDLE, RAMP, HOLD, DONE.
  - IDLE: enable=1 sets key index to 0 and moves to RAMP. Duty outputs keep their current values.
  - RAMP: on each tick, every channel not equal to its target moves 1 LSB toward it (increment if below, decrement if above). When all three channels equal the target, move to HOLD with the hold counter at 0. This check is made every cycle, so a key equal to the current duty goes to HOLD in 1 cycle.
  - HOLD: the hold counter increments on each tick. When it reaches HOLD_STEPS, advance; HOLD_STEPS=0 advances on the next cycle. Advance rules:
    - If index < KEYS_USED-1: increment the index and go to RAMP.
    - Else if loop=1: set the index to 0 and go to RAMP.
    - Else: pulse seq_done and go to DONE.
  - DONE: hold the duty outputs. When enable=0, go to IDLE.
- Disable: enable cleared in RAMP or HOLD goes to IDLE on the next cycle, the duty outputs freeze, and seq_done is not pulsed.
- Live writes: a KEY write during RAMP retargets immediately. A STEP_DIV write applies from the next prescaler wrap.
- Arithmetic: duty values never wrap, since steps are only ever toward the target.

Decomposition:
- Package rgb_fade_pkg holds:
  - the FSM state enum: IDLE=0, RAMP=1, HOLD=2, DONE=3;
  - the register address constants;
  - the STATUS field offsets.
- Sub-module step_tick_gen (DIV_W): prescaler with a clear input, a div input, and a tick output.

Test Plan:
- Reset mid-ramp: assert reset_n=0 while in RAMP -> duty outputs 0, busy 0, STATUS reads 0 after release.
- Single key: STEP_DIV=1, KEYS_USED=1, KEY0=(10,0,5), HOLD_STEPS=2, loop=0, enable=1 ->
  - red climbs 1 per cycle to 10 and blue reaches 5 then stops;
  - after 10 ticks, HOLD lasts 2 ticks;
  - seq_done pulses once and STATUS state=3.
- Ramp down with prescale: from (10,0,5), KEY0=(0,0,0), STEP_DIV=4 -> red decrements every 4th clock and reaches 0 after 40 clocks, no underflow.
- Loop: KEYS_USED=2, KEY0=(3,0,0), KEY1=(0,3,0), loop=1 -> the key index alternates 0,1,0,1, seq_done never asserts, busy stays 1.
- Disable mid-ramp: clear enable at red=4 -> red holds at 4, state IDLE, no seq_done pulse.
- Bus edges:
  - STEP_DIV=0 behaves as 1;
  - KEYS_USED=9 saturates to NUM_KEYS;
  - readdata appears 1 cycle after avs_read;
  - reading address 12 returns 0.

Source files
------------

// File: rtl/rgb_fade_pkg.sv
// rtl/rgb_fade_pkg.sv - shared state encoding, register map and STATUS layout for the RGB fade sequencer
package rgb_fade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } fade_state_t;

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_STEP_DIV   = 4'd1;
  localparam logic [3:0] ADDR_HOLD_STEPS = 4'd2;
  localparam logic [3:0] ADDR_KEYS_USED  = 4'd3;
  localparam logic [3:0] ADDR_KEY0       = 4'd4;
  localparam logic [3:0] ADDR_STATUS     = 4'd15;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_LOOP_BIT    = 1;
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_INDEX_LSB = 4;
  localparam int STATUS_BUSY_BIT  = 8;

endpackage

// File: rtl/rgb_fade_sequencer_step_tick_gen.sv
// rtl/rgb_fade_sequencer_step_tick_gen.sv - step-tick prescaler; divisor is sampled only at wrap or clear
module step_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = (cnt == div_q - DIV_W'(1));

  // div_q is never 0, so a programmed divisor of 0 runs as 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= DIV_W'(1);
    end else if (clear || tick) begin
      cnt   <= '0;
      div_q <= (div == '0) ? DIV_W'(1) : div;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - Avalon-MM keyframe fader stepping three PWM duty values toward programmed colours
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int NUM_KEYS = 4,
  parameter int DIV_W    = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [DUTY_W-1:0] duty_red,
  output logic [DUTY_W-1:0] duty_green,
  output logic [DUTY_W-1:0] duty_blue,
  output logic              busy,
  output logic              seq_done
);

  localparam int KEY_W = 3 * DUTY_W;

  logic              ctrl_enable, ctrl_loop;
  logic [DIV_W-1:0]  step_div;
  logic [15:0]       hold_steps, hold_cnt;
  logic [3:0]        keys_used, keys_used_eff;
  logic [KEY_W-1:0]  keys [8];
  logic [KEY_W-1:0]  target;
  logic [2:0]        key_idx;
  fade_state_t       state, next_state;
  logic              tick, prescale_clear, at_target, last_key;
  logic [31:0]       rd_data, status_word;
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata;

  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (cur < tgt) return cur + DUTY_W'(1);
    if (cur > tgt) return cur - DUTY_W'(1);
    return cur;
  endfunction

  step_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (prescale_clear),
    .div     (step_div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable <= 1'b0;
      ctrl_loop   <= 1'b0;
      step_div    <= '0;
      hold_steps  <= '0;
      keys_used   <= '0;
      for (int i = 0; i < 8; i++) keys[i] <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_CTRL: begin
          ctrl_enable <= avs_writedata[CTRL_ENABLE_BIT];
          ctrl_loop   <= avs_writedata[CTRL_LOOP_BIT];
        end
        ADDR_STEP_DIV:   step_div   <= avs_writedata[DIV_W-1:0];
        ADDR_HOLD_STEPS: hold_steps <= avs_writedata[15:0];
        ADDR_KEYS_USED:  keys_used  <= avs_writedata[3:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_KEYS; i++)
        if (avs_address == ADDR_KEY0 + 4'(i)) keys[i] <= avs_writedata[KEY_W-1:0];
    end
  end

  always_comb begin
    keys_used_eff = keys_used;
    if (keys_used == 4'd0) keys_used_eff = 4'd1;
    else if (keys_used > 4'(NUM_KEYS)) keys_used_eff = 4'(NUM_KEYS);
  end

  assign target    = keys[key_idx];
  assign at_target = ({duty_red, duty_green, duty_blue} == target);
  assign last_key  = ({1'b0, key_idx} >= keys_used_eff - 4'd1);
  assign busy      = (state == RAMP) || (state == HOLD);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ctrl_enable) next_state = RAMP;
      RAMP: begin
        if (!ctrl_enable)   next_state = IDLE;
        else if (at_target) next_state = HOLD;
      end
      HOLD: begin
        if (!ctrl_enable) next_state = IDLE;
        else if (hold_cnt >= hold_steps) next_state = (!last_key || ctrl_loop) ? RAMP : DONE;
      end
      DONE: if (!ctrl_enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    prescale_clear = (next_state == RAMP) && (state != RAMP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      key_idx    <= '0;
      hold_cnt   <= '0;
      seq_done   <= 1'b0;
      duty_red   <= '0;
      duty_green <= '0;
      duty_blue  <= '0;
    end else begin
      state    <= next_state;
      seq_done <= (state == HOLD) && (next_state == DONE);
      if (state == IDLE && next_state == RAMP) key_idx <= '0;
      else if (state == HOLD && next_state == RAMP) key_idx <= last_key ? 3'd0 : key_idx + 3'd1;
      if (state == RAMP) hold_cnt <= '0;
      else if (state == HOLD && tick) hold_cnt <= hold_cnt + 16'd1;
      // gating on enable keeps the duties frozen in the cycle a disable lands
      if (state == RAMP && ctrl_enable && tick) begin
        duty_red   <= step_toward(duty_red,   target[3*DUTY_W-1:2*DUTY_W]);
        duty_green <= step_toward(duty_green, target[2*DUTY_W-1:DUTY_W]);
        duty_blue  <= step_toward(duty_blue,  target[DUTY_W-1:0]);
      end
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_STATE_LSB +: 2] = state;
    status_word[STATUS_INDEX_LSB +: 3] = key_idx;
    status_word[STATUS_BUSY_BIT]       = busy;
  end

  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_CTRL:       rd_data = {30'd0, ctrl_loop, ctrl_enable};
      ADDR_STEP_DIV:   rd_data = 32'(step_div);
      ADDR_HOLD_STEPS: rd_data = 32'(hold_steps);
      ADDR_KEYS_USED:  rd_data = 32'(keys_used);
      ADDR_STATUS:     rd_data = status_word;
      default: ;
    endcase
    for (int i = 0; i < NUM_KEYS; i++)
      if (avs_address == ADDR_KEY0 + 4'(i)) rd_data = 32'(keys[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs_readdata <= '0;
    else          avs_readdata <= avs_read ? rd_data : '0;
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - self-checking bench for rgb_fade_sequencer
module tb_rgb_fade_sequencer;
  import rgb_fade_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [7:0]  duty_red, duty_green, duty_blue;
  logic        busy, seq_done;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.DUTY_W(8), .NUM_KEYS(4), .DIV_W(24)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .duty_red      (duty_red),
    .duty_green    (duty_green),
    .duty_blue     (duty_blue),
    .busy          (busy),
    .seq_done      (seq_done)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // all bus tasks start and end on a falling edge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(lvl));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n, first, pulses, sd, nb, nbs, maxidx, last_state;
    int q[$];

    vecs[0]  = '{1'b1, ADDR_CTRL,       32'h0000_0002, 32'h0000_0002};
    vecs[1]  = '{1'b1, ADDR_STEP_DIV,   32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, ADDR_STEP_DIV,   32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[3]  = '{1'b1, ADDR_HOLD_STEPS, 32'hFFFF_1234, 32'h0000_1234};
    vecs[4]  = '{1'b1, ADDR_KEYS_USED,  32'h0000_0009, 32'h0000_0009};
    vecs[5]  = '{1'b1, ADDR_KEYS_USED,  32'hFFFF_FFF0, 32'h0000_0000};
    vecs[6]  = '{1'b1, ADDR_KEY0,       32'hFFAB_CDEF, 32'h00AB_CDEF};
    vecs[7]  = '{1'b1, 4'd7,            32'h0012_3456, 32'h0012_3456};
    vecs[8]  = '{1'b1, 4'd8,            32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{1'b0, 4'd12,           32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{1'b1, ADDR_STATUS,     32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{1'b0, ADDR_KEY0,       32'h0000_0000, 32'h00AB_CDEF};
    vecs[12] = '{1'b1, 4'd14,           32'hFFFF_FFFF, 32'h0000_0000};

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_red", 32'(duty_red), 0);
    check("reset_green", 32'(duty_green), 0);
    check("reset_blue", 32'(duty_blue), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_seq_done", 32'(seq_done), 0);
    check("reset_readdata", avs_readdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // register map vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
    end

    // read latency: nothing before the edge, data one cycle after, cleared afterwards
    avs_address = 4'd7; avs_read = 1'b1;
    #1 check("rd_before_edge", avs_readdata, 0);
    @(negedge clk);
    avs_read = 1'b0;
    check("rd_one_cycle", avs_readdata, 32'h0012_3456);
    @(negedge clk);
    check("rd_cleared", avs_readdata, 0);

    // single key, STEP_DIV=1
    do_reset();
    bus_write(ADDR_STEP_DIV, 1);
    bus_write(ADDR_KEYS_USED, 1);
    bus_write(ADDR_KEY0, 32'h000A_0005);
    bus_write(ADDR_HOLD_STEPS, 2);
    bus_write(ADDR_CTRL, 1);
    wait_busy(1'b1, 10, "single_start");
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("single_red_k%0d", k), 32'(duty_red), 32'(k));
      if (k == 5 || k == 10) check($sformatf("single_blue_k%0d", k), 32'(duty_blue), 5);
    end
    check("single_green", 32'(duty_green), 0);
    first = 0; pulses = 0;
    for (int k = 11; k <= 20; k++) begin
      @(negedge clk);
      if (k == 13) check("single_busy_in_hold", 32'(busy), 1);
      if (seq_done) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check("single_done_cycle", first, 14);
    check("single_done_pulses", pulses, 1);
    check("single_busy_done", 32'(busy), 0);
    bus_read(ADDR_STATUS, rd);
    check("single_status", rd, 32'h3);

    // ramp down with STEP_DIV=4 from (10,0,5)
    bus_write(ADDR_KEY0, 0);
    bus_write(ADDR_STEP_DIV, 4);
    bus_write(ADDR_CTRL, 0);
    bus_write(ADDR_CTRL, 1);
    wait_busy(1'b1, 10, "down_start");
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3)  check("down_red_k3", 32'(duty_red), 10);
      if (k == 4)  check("down_red_k4", 32'(duty_red), 9);
      if (k == 20) check("down_blue_k20", 32'(duty_blue), 0);
      if (k == 39) check("down_red_k39", 32'(duty_red), 1);
      if (k == 40) check("down_red_k40", 32'(duty_red), 0);
    end
    for (int k = 0; k < 30; k++) @(negedge clk);
    check("down_no_underflow", 32'(duty_red), 0);
    check("down_blue_final", 32'(duty_blue), 0);
    check("down_done", 32'(busy), 0);

    // disable mid-ramp
    do_reset();
    bus_write(ADDR_STEP_DIV, 8);
    bus_write(ADDR_KEYS_USED, 1);
    bus_write(ADDR_KEY0, 32'h000A_0000);
    bus_write(ADDR_CTRL, 1);
    wait_busy(1'b1, 10, "dis_start");
    n = 0;
    while (duty_red != 8'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dis_reach4", 32'(duty_red), 4);
    bus_write(ADDR_CTRL, 0);
    sd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (seq_done) sd++;
    end
    check("dis_red_frozen", 32'(duty_red), 4);
    check("dis_busy", 32'(busy), 0);
    check("dis_no_seq_done", sd, 0);
    bus_read(ADDR_STATUS, rd);
    check("dis_status", rd, 0);

    // STEP_DIV=0 as 1, KEYS_USED=9 saturates to 4
    do_reset();
    bus_write(ADDR_STEP_DIV, 0);
    bus_write(ADDR_KEYS_USED, 9);
    bus_write(ADDR_HOLD_STEPS, 0);
    bus_write(ADDR_KEY0, 32'h0001_0000);
    bus_write(4'd5, 32'h0000_0100);
    bus_write(4'd6, 32'h0000_0001);
    bus_write(4'd7, 32'h0001_0101);
    bus_write(ADDR_CTRL, 1);
    wait_busy(1'b1, 10, "sat_start");
    @(negedge clk);
    check("div0_red_step", 32'(duty_red), 1);
    maxidx = 0; sd = 0; last_state = 0;
    for (int k = 0; k < 100 && last_state != 3; k++) begin
      bus_read(ADDR_STATUS, rd);
      if (seq_done) sd++;
      if (int'(rd[6:4]) > maxidx) maxidx = int'(rd[6:4]);
      last_state = int'(rd[1:0]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (seq_done) sd++;
    end
    check("sat_max_index", maxidx, 3);
    check("sat_final_state", last_state, 3);
    check("sat_seq_done", sd, 1);
    check("sat_final_green", 32'(duty_green), 1);

    // looping over two keys
    do_reset();
    bus_write(ADDR_STEP_DIV, 1);
    bus_write(ADDR_KEYS_USED, 2);
    bus_write(ADDR_HOLD_STEPS, 0);
    bus_write(ADDR_KEY0, 32'h0003_0000);
    bus_write(4'd5, 32'h0000_0300);
    bus_write(ADDR_CTRL, 3);
    wait_busy(1'b1, 10, "loop_start");
    sd = 0; nb = 0; nbs = 0;
    for (int k = 0; k < 60; k++) begin
      bus_read(ADDR_STATUS, rd);
      if (seq_done) sd++;
      if (!busy) nb++;
      if (!rd[8]) nbs++;
      if (q.size() == 0 || q[q.size()-1] != int'(rd[6:4])) q.push_back(int'(rd[6:4]));
    end
    check("loop_seq_len", 32'(q.size() >= 4), 1);
    if (q.size() >= 4)
      for (int i = 0; i < 4; i++) check($sformatf("loop_idx%0d", i), q[i], i % 2);
    check("loop_no_seq_done", sd, 0);
    check("loop_busy_port", nb, 0);
    check("loop_busy_status", nbs, 0);

    // reset while ramping toward key 1
    n = 0;
    while (!(duty_red == 8'd2 && duty_green == 8'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_found", 32'(busy && duty_red == 8'd2), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_red", 32'(duty_red), 0);
    check("rst_mid_green", 32'(duty_green), 0);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_STATUS, rd);
    check("rst_mid_status", rd, 0);
    bus_read(ADDR_CTRL, rd);
    check("rst_mid_ctrl", rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
